// File: rtl/vecmat_h_pack_pkg.sv
// Shared constants and FSM encoding for the hidden-state vector-matrix packer.
//   ELEM_WIDTH : bits per fixed-point element
//   VECTWIDTH  : elements per vector
//   UARRAYSIZE : packed bus width (ELEM_WIDTH * VECTWIDTH)
//   pack_state_e : packer FSM states (FILL=0, HOLD=1)
package vecmat_h_pack_pkg;

  localparam int unsigned ELEM_WIDTH = 16;
  localparam int unsigned VECTWIDTH  = 64;
  localparam int unsigned UARRAYSIZE = ELEM_WIDTH * VECTWIDTH;

  typedef enum logic [0:0] {
    StFill = 1'b0,
    StHold = 1'b1
  } pack_state_e;

endpackage

// File: rtl/vec_slot_mask.sv
// Combinational slot mask: passes elements [0, len) of a packed vector and
// forces elements at index >= len to zero.
//   vec    : packed input vector, element i at [i*ElemWidth +: ElemWidth]
//   len    : number of leading elements to keep (0..NumElems)
//   masked : packed output vector, same layout
module vec_slot_mask
  import vecmat_h_pack_pkg::*;
#(
  parameter int unsigned ElemWidth = ELEM_WIDTH,
  parameter int unsigned NumElems  = VECTWIDTH,
  parameter int unsigned LenWidth  = $clog2(NumElems + 1)
) (
  input  logic [ElemWidth*NumElems-1:0] vec,
  input  logic [LenWidth-1:0]           len,
  output logic [ElemWidth*NumElems-1:0] masked
);

  for (genvar i = 0; i < NumElems; i++) begin : g_slot
    assign masked[i*ElemWidth +: ElemWidth] =
        (LenWidth'(i) < len) ? vec[i*ElemWidth +: ElemWidth] : '0;
  end

endmodule

// File: rtl/vecmat_h_pack.sv
// Input-side packer for the hidden-state vector-matrix unit. Collects one
// (h, W) element pair per handshake into a fill buffer and transfers the
// completed vector into an output register pair (double buffering). Vectors
// closed early by in_last are zero-padded on transfer.
//   clk, reset        : clock, asynchronous active-low reset
//   in_valid/in_ready : input pair handshake; in_h, in_w, in_last payload
//   out_valid/out_ready : output vector handshake; data_h, W_h packed buses
//   short_vec         : one-cycle pulse after an early close
//   fill_count        : elements currently in the fill buffer (0..VECTWIDTH)
module vecmat_h_pack #(
  parameter int unsigned ELEM_WIDTH = vecmat_h_pack_pkg::ELEM_WIDTH,
  parameter int unsigned VECTWIDTH  = vecmat_h_pack_pkg::VECTWIDTH,
  parameter int unsigned UARRAYSIZE = vecmat_h_pack_pkg::UARRAYSIZE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ELEM_WIDTH-1:0]          in_h,
  input  logic [ELEM_WIDTH-1:0]          in_w,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [UARRAYSIZE-1:0]          data_h,
  output logic [UARRAYSIZE-1:0]          W_h,
  output logic                           short_vec,
  output logic [$clog2(VECTWIDTH+1)-1:0] fill_count
);

  import vecmat_h_pack_pkg::*;

  localparam int unsigned CntWidth = $clog2(VECTWIDTH + 1);
  localparam int unsigned IdxWidth = $clog2(VECTWIDTH);
  localparam logic [CntWidth-1:0] LastSlot = CntWidth'(VECTWIDTH - 1);

  pack_state_e state_q, state_d;

  // cnt_q doubles as the write slot index while filling and as the held
  // vector length while in HOLD.
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  run_q;
  logic [UARRAYSIZE-1:0] fill_h_q, fill_h_d;
  logic [UARRAYSIZE-1:0] fill_w_q, fill_w_d;
  logic                  out_valid_q, out_valid_d;
  logic                  short_q, short_d;
  logic [UARRAYSIZE-1:0] data_h_q, w_out_q;

  logic [IdxWidth-1:0]   slot;
  logic                  accept, closing, consume, out_free, xfer;
  logic [CntWidth-1:0]   xfer_len;
  logic [UARRAYSIZE-1:0] merge_h, merge_w;
  logic [UARRAYSIZE-1:0] xfer_h, xfer_w;
  logic [UARRAYSIZE-1:0] masked_h, masked_w;

  // run_q keeps in_ready low until the first clock after reset release.
  assign in_ready = run_q && (state_q == StFill);
  assign slot     = cnt_q[IdxWidth-1:0];
  assign accept   = in_valid && in_ready;
  assign closing  = accept && (in_last || (cnt_q == LastSlot));
  assign consume  = out_valid_q && out_ready;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_h_d    = fill_h_q;
    fill_w_d    = fill_w_q;
    out_valid_d = out_valid_q;
    short_d     = 1'b0;
    xfer        = 1'b0;
    xfer_len    = cnt_q;
    xfer_h      = fill_h_q;
    xfer_w      = fill_w_q;

    // Fill buffer with the incoming pair merged in, so a closing element can
    // bypass straight into the output register.
    merge_h = fill_h_q;
    merge_w = fill_w_q;
    merge_h[slot*ELEM_WIDTH +: ELEM_WIDTH] = in_h;
    merge_w[slot*ELEM_WIDTH +: ELEM_WIDTH] = in_w;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          fill_h_d = merge_h;
          fill_w_d = merge_w;
          if (closing) begin
            short_d = in_last && (cnt_q != LastSlot);
            if (out_free) begin
              xfer     = 1'b1;
              xfer_len = cnt_q + CntWidth'(1);
              xfer_h   = merge_h;
              xfer_w   = merge_w;
              cnt_d    = '0;
            end else begin
              state_d = StHold;
              cnt_d   = cnt_q + CntWidth'(1);
            end
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end
      StHold: begin
        if (consume) begin
          xfer    = 1'b1;
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    // A transfer in the same cycle as a consume keeps out_valid high.
    if (xfer) begin
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  vec_slot_mask #(
    .ElemWidth(ELEM_WIDTH),
    .NumElems (VECTWIDTH),
    .LenWidth (CntWidth)
  ) u_mask_h (
    .vec   (xfer_h),
    .len   (xfer_len),
    .masked(masked_h)
  );

  vec_slot_mask #(
    .ElemWidth(ELEM_WIDTH),
    .NumElems (VECTWIDTH),
    .LenWidth (CntWidth)
  ) u_mask_w (
    .vec   (xfer_w),
    .len   (xfer_len),
    .masked(masked_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFill;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      fill_h_q    <= '0;
      fill_w_q    <= '0;
      out_valid_q <= 1'b0;
      short_q     <= 1'b0;
      data_h_q    <= '0;
      w_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= 1'b1;
      fill_h_q    <= fill_h_d;
      fill_w_q    <= fill_w_d;
      out_valid_q <= out_valid_d;
      short_q     <= short_d;
      if (xfer) begin
        data_h_q <= masked_h;
        w_out_q  <= masked_w;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign short_vec  = short_q;
  assign fill_count = cnt_q;
  assign data_h     = data_h_q;
  assign W_h        = w_out_q;

endmodule

// File: tb/tb_vecmat_h_pack.sv
// Self-checking bench for vecmat_h_pack. A stream-level reference model keeps
// the queue of completed vectors (at most two: output + held) and the partial
// vector being assembled; zero padding falls out of starting each vector at 0.
module tb_vecmat_h_pack;

  localparam int EW = 16;
  localparam int NV = 64;
  localparam int BW = EW * NV;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_last;
  logic [EW-1:0] in_h, in_w;
  logic          out_valid, out_ready, short_vec;
  logic [BW-1:0] data_h, W_h;
  logic [6:0]    fill_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vecmat_h_pack dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_h      (in_h),
    .in_w      (in_w),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_h    (data_h),
    .W_h       (W_h),
    .short_vec (short_vec),
    .fill_count(fill_count)
  );

  // Reference model state
  logic [BW-1:0] mq_h[$];
  logic [BW-1:0] mq_w[$];
  int            mq_len[$];
  logic [BW-1:0] cur_h, cur_w;
  int            cur_n;
  bit            m_run, m_short;

  int            short_seen, vec_seen;
  logic [EW-1:0] src_h[NV];
  logic [EW-1:0] src_w[NV];

  typedef struct {
    int len;
    bit use_last;
    int exp_pulses;
    int exp_vecs;
    int exp_fill;
  } vec_case_t;

  vec_case_t cases[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      int k;
      k = 0;
      for (int i = NV - 1; i >= 0; i--) begin
        if (act[i*EW +: EW] !== exp[i*EW +: EW]) k = i;
      end
      errors++;
      $display("FAIL %s: slot %0d got %0h expected %0h at %0t", name, k,
               act[k*EW +: EW], exp[k*EW +: EW], $time);
    end
  endtask

  function automatic bit m_ready();
    return m_run && (mq_h.size() < 2);
  endfunction

  task automatic model_clear();
    mq_h.delete();
    mq_w.delete();
    mq_len.delete();
    cur_h   = '0;
    cur_w   = '0;
    cur_n   = 0;
    m_run   = 1'b0;
    m_short = 1'b0;
  endtask

  task automatic model_edge(input bit acc, input logic [EW-1:0] h, input logic [EW-1:0] w,
                            input bit last, input bit ordy);
    logic [BW-1:0] tmp;
    int            tmp_len;
    m_short = 1'b0;
    if (!reset) return;
    if (mq_h.size() > 0 && ordy) begin
      tmp     = mq_h.pop_front();
      tmp     = mq_w.pop_front();
      tmp_len = mq_len.pop_front();
    end
    if (acc) begin
      cur_h[cur_n*EW +: EW] = h;
      cur_w[cur_n*EW +: EW] = w;
      cur_n++;
      if (cur_n == NV || last) begin
        mq_h.push_back(cur_h);
        mq_w.push_back(cur_w);
        mq_len.push_back(cur_n);
        m_short = last && (cur_n < NV);
        cur_h   = '0;
        cur_w   = '0;
        cur_n   = 0;
      end
    end
    m_run = 1'b1;
  endtask

  task automatic check_outputs();
    int exp_fc;
    exp_fc = (mq_h.size() == 2) ? mq_len[1] : cur_n;
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("out_valid", 32'(out_valid), 32'(mq_h.size() > 0));
    chk("short_vec", 32'(short_vec), 32'(m_short));
    chk("fill_count", 32'(fill_count), 32'(exp_fc));
    if (mq_h.size() > 0) begin
      chk_vec("data_h", data_h, mq_h[0]);
      chk_vec("W_h", W_h, mq_w[0]);
    end
    if (short_vec) short_seen++;
  endtask

  // One cycle: check at the negedge, drive, advance the model at the posedge.
  task automatic step(input bit iv, input logic [EW-1:0] h, input logic [EW-1:0] w,
                      input bit last, input bit ordy, output bit acc);
    check_outputs();
    in_valid  = iv;
    in_h      = h;
    in_w      = w;
    in_last   = last;
    out_ready = ordy;
    acc = iv && m_ready();
    if (out_valid && ordy) vec_seen++;
    @(posedge clk);
    model_edge(acc, h, w, last, ordy);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, ordy, acc);
  endtask

  task automatic feed(input int n, input bit use_last, input int vpct, input int rpct);
    int idx;
    int budget;
    bit acc;
    idx    = 0;
    budget = 0;
    while (idx < n) begin
      bit iv;
      bit ordy;
      iv   = ($urandom_range(99) < vpct);
      ordy = ($urandom_range(99) < rpct);
      step(iv, iv ? src_h[idx] : 16'($urandom), iv ? src_w[idx] : 16'($urandom),
           iv && use_last && (idx == n - 1), ordy, acc);
      if (acc) idx++;
      budget++;
      if (budget > 4000) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout: accepted %0d required %0d", idx, n);
        return;
      end
    end
  endtask

  task automatic src_ramp();
    for (int i = 0; i < NV; i++) begin
      src_h[i] = 16'(i);
      src_w[i] = 16'(-i);
    end
  endtask

  task automatic src_rand();
    for (int i = 0; i < NV; i++) begin
      src_h[i] = 16'($urandom);
      src_w[i] = 16'($urandom);
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_short_vec"}, 32'(short_vec), 32'd0);
    chk({tag, "_fill_count"}, 32'(fill_count), 32'd0);
    chk_vec({tag, "_data_h"}, data_h, '0);
    chk_vec({tag, "_W_h"}, W_h, '0);
    model_clear();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dut_acc;
    int base;
    bit acc;

    cases[0] = '{len: 10, use_last: 1'b1, exp_pulses: 1, exp_vecs: 1, exp_fill: 0};
    cases[1] = '{len: 1,  use_last: 1'b1, exp_pulses: 1, exp_vecs: 1, exp_fill: 0};
    cases[2] = '{len: 63, use_last: 1'b1, exp_pulses: 1, exp_vecs: 1, exp_fill: 0};
    cases[3] = '{len: 64, use_last: 1'b1, exp_pulses: 0, exp_vecs: 1, exp_fill: 0};
    cases[4] = '{len: 64, use_last: 1'b0, exp_pulses: 0, exp_vecs: 1, exp_fill: 0};
    cases[5] = '{len: 32, use_last: 1'b0, exp_pulses: 0, exp_vecs: 0, exp_fill: 32};
    cases[6] = '{len: 32, use_last: 1'b1, exp_pulses: 0, exp_vecs: 1, exp_fill: 0};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_h      = '0;
    in_w      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    short_seen = 0;
    vec_seen   = 0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_short_vec", 32'(short_vec), 32'd0);
    chk("rst_fill_count", 32'(fill_count), 32'd0);
    chk_vec("rst_data_h", data_h, '0);
    chk_vec("rst_W_h", W_h, '0);
    reset = 1'b1;
    idle(2, 1'b1);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Full ramp vector
    src_ramp();
    short_seen = 0;
    feed(64, 1'b0, 100, 100);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_h_slot5", 32'(data_h[5*EW +: EW]), 32'h0005);
    chk("full_h_slot63", 32'(data_h[63*EW +: EW]), 32'h003f);
    chk("full_w_slot63", 32'(W_h[63*EW +: EW]), 32'hffc1);
    idle(2, 1'b1);
    chk("full_no_short", 32'(short_seen), 32'd0);

    // Table of vector lengths and close conditions
    foreach (cases[c]) begin
      src_rand();
      short_seen = 0;
      base       = vec_seen;
      feed(cases[c].len, cases[c].use_last, 70, 100);
      idle(3, 1'b1);
      chk($sformatf("case%0d_pulses", c), 32'(short_seen), 32'(cases[c].exp_pulses));
      chk($sformatf("case%0d_vecs", c), 32'(vec_seen - base), 32'(cases[c].exp_vecs));
      chk($sformatf("case%0d_fill", c), 32'(fill_count), 32'(cases[c].exp_fill));
    end

    // Backpressure: two vectors with out_ready low, then a single consume
    src_rand();
    feed(64, 1'b0, 100, 0);
    src_rand();
    feed(64, 1'b0, 100, 0);
    idle(3, 1'b0);
    chk("bp_in_ready_held", 32'(in_ready), 32'd0);
    chk("bp_out_valid_held", 32'(out_valid), 32'd1);
    chk("bp_fill_count_held", 32'(fill_count), 32'd64);
    idle(1, 1'b1);
    chk("bp_out_valid_swap", 32'(out_valid), 32'd1);
    idle(1, 1'b0);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    idle(2, 1'b1);

    // Back-to-back: 256 accepts in 256 cycles
    dut_acc = 0;
    base    = vec_seen;
    for (int i = 0; i < 256; i++) begin
      if (in_ready) dut_acc++;
      step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, acc);
    end
    idle(2, 1'b1);
    chk("b2b_accepts", 32'(dut_acc), 32'd256);
    chk("b2b_vectors", 32'(vec_seen - base), 32'd4);

    // Asynchronous reset mid-vector, then a clean vector from slot 0
    src_rand();
    feed(30, 1'b0, 100, 100);
    async_reset_check("midrst");
    idle(2, 1'b1);
    reset = 1'b1;
    idle(1, 1'b1);
    src_ramp();
    feed(64, 1'b0, 100, 100);
    chk("midrst_h_slot40", 32'(data_h[40*EW +: EW]), 32'h0028);
    chk("midrst_w_slot0", 32'(W_h[0 +: EW]), 32'h0000);
    idle(2, 1'b1);

    // Stall tolerance with random in_valid, then mixed random traffic
    src_rand();
    feed(64, 1'b0, 50, 100);
    for (int v = 0; v < 6; v++) begin
      src_rand();
      feed(int'($urandom_range(1, 64)), 1'b1, 60, 50);
    end
    idle(6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vecmat_h_pack.md
# vecmat_h_pack

Input-side packer for the hidden-state vector-matrix unit. It accepts one (h, W) element pair per cycle over a valid/ready stream and assembles them into the two 1024-bit buses `data_h` and `W_h` that the `vecmat_h_*` multiply/add datapath consumes. The packer double-buffers (fill register plus output register), so a new vector can stream in while the previous one waits for the datapath. It also pads short vectors with zeros.

## Interface
Parameters:
- `ELEM_WIDTH`, 16, bits per element (fixed-point, signed).
- `VECTWIDTH`, 64, elements per vector.
- `UARRAYSIZE`, 1024, bus width; must equal `ELEM_WIDTH*VECTWIDTH`.

Ports:
- `clk`, in, 1, single clock. All logic is on the rising edge.
- `reset`, in, 1, asynchronous, active-low reset.
- `in_valid`, in, 1, the element pair on `in_h`/`in_w` is valid.
- `in_ready`, out, 1, the packer can accept a pair this cycle.
- `in_h`, in, 16, hidden-state element.
- `in_w`, in, 16, weight element.
- `in_last`, in, 1, final element of the current vector.
- `out_valid`, out, 1, `data_h`/`W_h` hold a complete vector.
- `out_ready`, in, 1, the datapath takes the vector this cycle.
- `data_h`, out, `UARRAYSIZE`, packed h vector. Element i is at `[i*16 +: 16]`.
- `W_h`, out, `UARRAYSIZE`, packed weight vector, same layout.
- `short_vec`, out, 1, one-cycle pulse when a vector is closed early by `in_last`.
- `fill_count`, out, 7, number of elements in the fill buffer (0..64).

## Operation
- A handshake occurs when `in_valid && in_ready`. The pair is written to element slot `idx` of the fill buffers, then `idx` increments.
- A vector closes on an accepted pair when `idx==VECTWIDTH-1` or `in_last==1`.
- Early close (`in_last` with `idx<63`):
  - Slots `idx+1..63` are forced to zero in the transferred vector by masking on transfer, not by clearing the fill buffer.
  - `short_vec` pulses in the cycle after the handshake.
- `in_last` on slot 63 is a normal close, with no pulse.
- Transfer to the output registers happens on close when the output register is free: `!out_valid`, or `out_valid && out_ready` in the same cycle. On transfer, `idx` returns to 0.
- FSM states:
  - **FILL**: `in_ready=1`. On close with the output free, transfer and stay in FILL. On close with the output busy, go to HOLD.
  - **HOLD**: `in_ready=0`, fill buffer frozen, `fill_count` reads 64 (or the short length). When `out_ready && out_valid`, transfer the fill buffer, return to FILL, and clear `idx`.
- Output side:
  - `out_valid` is set on transfer and cleared on `out_valid && out_ready` unless a transfer happens in the same cycle.
  - Simultaneous consume and transfer keeps `out_valid=1` with the new data, so there is no bubble.
- `data_h`/`W_h` are stable while `out_valid && !out_ready`.
- Reset asserted mid-vector discards partial and held data. There is no partial output.

## Timing
- Reset values:
  - `in_ready=0` while reset is asserted, then 1 in the first cycle after release.
  - `out_valid=0`, `short_vec=0`, `fill_count=0`, `data_h=0`, `W_h=0`.
  - FSM is in FILL, `idx=0`.
- Latency: `out_valid` rises on the clock edge that accepts the closing element, i.e. it is visible the cycle after that handshake.
- Throughput: with `out_ready` held at 1, one vector every 64 cycles with no gaps. A new vector's slot 0 can be accepted in the cycle after close.
- `in_ready` depends only on registered state, never combinationally on `out_ready`.

## Structure
- The shared LSTM package holds `ELEM_WIDTH`, `VECTWIDTH` and `UARRAYSIZE` (the current `DATA_WIDTH`, `ARRAY_DEPTH` and `uarraysize` macros), plus the FSM state encoding (FILL=0, HOLD=1).
- One sub-module, `vec_slot_mask`: combinational and parameterised, it zeroes elements at index ≥ len. It is used on both the h and W transfer paths.

## Test plan
- **Full vector:** stream pairs with `in_h=i`, `in_w=-i` for i=0..63, `out_ready=1`.
  - `out_valid` rises the cycle after i=63.
  - `data_h[i*16+:16]==i` and `W_h[i*16+:16]==-i`.
  - `short_vec` never pulses.
- **Short vector:** 10 pairs with `in_last` on the 10th.
  - `out_valid` rises and `short_vec` pulses once.
  - Slots 0..9 hold the data and slots 10..63 are 0.
- **Backpressure:** `out_ready=0`, send two full vectors.
  - The first vector appears; the second fills, then `in_ready=0` with the FSM in HOLD.
  - The outputs keep vector 1.
  - Raising `out_ready` for one cycle loads vector 2 with `out_valid` staying 1.
  - `in_ready` returns to 1.
- **Back-to-back:** 4 full vectors with `in_valid=1` continuously and `out_ready=1`.
  - 256 accepts in 256 cycles.
  - `out_valid` rises every 64 cycles, and each output is correct.
- **Reset mid-operation:** assert `reset=0` asynchronously after 30 pairs.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh 64-pair vector packs from slot 0 with no stale data.
- **Stall tolerance:** `in_valid` toggled randomly across 64 pairs.
  - The output matches the accepted sequence in order.
  - `fill_count` tracks the accepted count exactly.
